scatter_crossbar: RTL and testbench
===================================

Name: scatter_crossbar

Overview:
- Push-direction counterpart of the registered gather crossbar. Each of N = 1 << W input ports carries its own destination index.
- Per-output round-robin arbiters resolve conflicts when several inputs target the same output.
- Each output has a one-entry holding register with valid/ready handshake, so contention and downstream backpressure stall the losing inputs instead of dropping data.
- Sits between the SIMD lane datapath and the storage-side ports.

Parameters:
- DW, 16, data width per port.
- W, 4, log2 of port count; N = 1 << W inputs and N outputs.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1 [N]  input i holds a word.
- in_data  input  DW [N]  payload of input i.
- in_dst  input  W [N]  destination output index of input i.
- in_ready  output  1 [N]  input i's word is accepted this cycle.
- out_valid  output  1 [N]  output j holding register is full.
- out_data  output  DW [N]  payload held at output j.
- out_src  output  W [N]  index of the input that supplied out_data[j].
- out_ready  input  1 [N]  downstream consumes output j this cycle.

Behaviour:
- Reset (rst=1, async):
  - out_valid, out_data, out_src and every arbiter pointer ptr[j] go to 0 immediately.
  - in_ready is forced to 0 while rst=1.
- Handshake:
  - Transfer on in_valid&&in_ready, and separately on out_valid&&out_ready.
  - Once in_valid[i] is asserted, the source holds in_data[i] and in_dst[i] stable until accepted.
  - out_valid/out_data/out_src stay stable until out_ready.
- Per output j, each cycle:
  - req[j][i] = in_valid[i] && in_dst[i]==j.
  - space[j] = !out_valid[j] || out_ready[j].
  - If space[j] and any req: grant the first requesting i searching ptr[j], ptr[j]+1, ... mod N.
  - in_ready[i] = 1 only for the granted input.
  - Each input requests exactly one output, so each input receives at most one grant.
- in_ready is combinational from in_valid, in_dst, out_valid, out_ready and ptr. It has no dependence on in_data.
- On grant to input i at output j (next posedge):
  - out_valid[j]<=1, out_data[j]<=in_data[i], out_src[j]<=i.
  - ptr[j]<=(i+1) mod N, with natural wrap from N-1 to 0.
- No grant and out_ready[j]&&out_valid[j]: out_valid[j]<=0. out_data and out_src keep their old values.
- Simultaneous drain and refill on the same output: the new word loads, out_valid stays 1, and there is no bubble. Throughput is 1 word per output per cycle.
- Latency: 1 cycle from accepted input to out_valid.
- ptr[j] changes only on a grant at j. Idle cycles do not move it.
- Fairness: a continuously valid input is granted within N grants of its destination.
- Distinct destinations never interact. A full permutation moves N words per cycle.
- No data loss or duplication: every accepted word appears exactly once on its in_dst output.
- Reset mid-operation: held words are discarded, pointers return to 0, and sources must re-present pending words after rst falls.
- Implementation: generate loop over outputs, each with an N-way rotating priority arbiter. Input-side in_ready is the OR of grants.

Test Plan:
- Identity: W=2, all four inputs valid with in_dst[i]=i, data 0x10+i, out_ready=1.
  - All in_ready=1 in cycle 0.
  - Cycle 1: out_data[i]=0x10+i, out_src[i]=i, out_valid=4'b1111.
- Reversal permutation, streaming 8 words per input with in_dst[i]=3-i:
  - Every output shows a word each cycle with no bubbles.
  - Output j carries input 3-j's data in order.
- All-to-one: W=2, inputs 0..3 valid with in_dst=2, out_ready=1.
  - Grants in order 0,1,2,3 on consecutive cycles.
  - out_src[2] sequence is 0,1,2,3.
  - Final ptr[2] wraps to 0.
  - Other outputs stay out_valid=0.
- Backpressure: out_ready[1]=0 for 5 cycles with inputs 0 and 3 targeting output 1.
  - First word held stable at output 1.
  - in_ready[0] and in_ready[3] stay 0 after the first grant.
  - After release, remaining words drain round-robin with no loss.
- Round-robin fairness: input 0 continuously targets output 0 while input 2 joins at cycle 3.
  - Grants alternate 0,2,0,2, and no input waits more than N cycles.
- Async reset mid-stream: assert rst between clock edges while out_valid=4'b1011.
  - out_valid=0 and in_ready=0 immediately, without waiting for a clock edge.
  - After release, the first grant at each output starts from input 0.

Source files
------------

// File: rtl/scatter_crossbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scatter_crossbar: N-input to N-output push crossbar with per-output  |
// | round-robin arbitration and one-entry valid/ready holding registers. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scatter_crossbar #(
  parameter int DW = 16,
  parameter int W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(1<<W)-1:0]          in_valid,
  input  logic [(1<<W)-1:0][DW-1:0]  in_data,
  input  logic [(1<<W)-1:0][W-1:0]   in_dst,
  output logic [(1<<W)-1:0]          in_ready,
  output logic [(1<<W)-1:0]          out_valid,
  output logic [(1<<W)-1:0][DW-1:0]  out_data,
  output logic [(1<<W)-1:0][W-1:0]   out_src,
  input  logic [(1<<W)-1:0]          out_ready
);

  localparam int N = 1 << W;

  // grant[j][i]: output j accepts the word from input i this cycle
  logic [N-1:0][N-1:0] grant;

  generate
    for (genvar j = 0; j < N; j++) begin : g_out
      logic [N-1:0]    req;
      logic            any_req;
      logic [W-1:0]    win;
      logic [W-1:0]    idx;
      logic            space;
      logic            take;
      logic            valid_q, valid_d;
      logic [DW-1:0]   data_q, data_d;
      logic [W-1:0]    src_q, src_d;
      logic [W-1:0]    ptr_q, ptr_d;

      always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
          req[i] = in_valid[i] && (in_dst[i] == W'(j));
        end
      end

      // Rotating priority: first requester at or after ptr_q, wrapping through W-bit overflow
      always_comb begin
        any_req = 1'b0;
        win     = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < N; k++) begin
          idx = ptr_q + W'(k);
          if (!any_req && req[idx]) begin
            any_req = 1'b1;
            win     = idx;
          end
        end
      end

      assign space    = !valid_q || out_ready[j];
      assign take     = space && any_req;
      assign grant[j] = take ? (N'(1) << win) : '0;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (take) begin
          valid_d = 1'b1;
          data_d  = in_data[win];
          src_d   = win;
          ptr_d   = win + W'(1);
        end else if (out_ready[j]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          src_q   <= '0;
          ptr_q   <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          src_q   <= src_d;
          ptr_q   <= ptr_d;
        end
      end

      assign out_valid[j] = valid_q;
      assign out_data[j]  = data_q;
      assign out_src[j]   = src_q;
    end
  endgenerate

  // Each input targets one output, so at most one grant bit per input is set
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N; j++) begin
      in_ready = in_ready | grant[j];
    end
    if (rst) begin
      in_ready = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scatter_crossbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scatter_crossbar: self-checking bench for scatter_crossbar (W=2). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_scatter_crossbar;

  localparam int DW = 16;
  localparam int W  = 2;
  localparam int N  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            in_valid;
  logic [N-1:0][DW-1:0]    in_data;
  logic [N-1:0][W-1:0]     in_dst;
  logic [N-1:0]            in_ready;
  logic [N-1:0]            out_valid;
  logic [N-1:0][DW-1:0]    out_data;
  logic [N-1:0][W-1:0]     out_src;
  logic [N-1:0]            out_ready;

  int tests = 0;
  int fails = 0;

  logic          m_valid [N];
  logic [DW-1:0] m_data  [N];
  int            m_src   [N];
  int            m_ptr   [N];

  always #5 clk = ~clk;

  scatter_crossbar #(.DW(DW), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dst    (in_dst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_valid[j] = 1'b0;
      m_data[j]  = '0;
      m_src[j]   = 0;
      m_ptr[j]   = 0;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: check DUT against the reference at mid-cycle, then advance the reference.
  task automatic cycle_check(input string tag, output logic [N-1:0] got_rdy);
    int                   win [N];
    int                   best;
    int                   d;
    logic [N-1:0]         exp_rdy;
    logic [N-1:0]         exp_ov;
    logic [N-1:0][DW-1:0] exp_od;
    logic [N-1:0][W-1:0]  exp_os;
    logic [N-1:0][DW-1:0] snap_data;
    logic [N-1:0]         snap_ordy;
    @(negedge clk);
    exp_rdy = '0;
    for (int j = 0; j < N; j++) begin
      win[j] = -1;
      best   = N;
      if (!m_valid[j] || out_ready[j]) begin
        for (int i = 0; i < N; i++) begin
          if (in_valid[i] && int'(in_dst[i]) == j) begin
            d = (i - m_ptr[j] + N) % N;
            if (d < best) begin
              best   = d;
              win[j] = i;
            end
          end
        end
      end
      if (win[j] >= 0) exp_rdy[win[j]] = 1'b1;
      exp_ov[j] = m_valid[j];
      exp_od[j] = m_data[j];
      exp_os[j] = W'(m_src[j]);
    end
    got_rdy   = in_ready;
    snap_data = in_data;
    snap_ordy = out_ready;
    chk({tag, "_rdy"}, 64'(in_ready), 64'(exp_rdy));
    chk({tag, "_ov"},  64'(out_valid), 64'(exp_ov));
    chk({tag, "_data"}, out_data, exp_od);
    chk({tag, "_src"}, 64'(out_src), 64'(exp_os));
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      if (win[j] >= 0) begin
        m_valid[j] = 1'b1;
        m_data[j]  = snap_data[win[j]];
        m_src[j]   = win[j];
        m_ptr[j]   = (win[j] + 1) % N;
      end else if (snap_ordy[j] && m_valid[j]) begin
        m_valid[j] = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [7:0] dst;
    logic [3:0] exp_rdy;
    logic [3:0] exp_ov;
  } vec_t;

  vec_t         tbl [6];
  logic [N-1:0] r;
  logic [N-1:0] exp_g;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_dst    = '0;
    out_ready = '1;

    // Fresh reset: pointers at 0, lowest-index requester wins each output
    tbl[0] = '{v: 4'b1111, dst: 8'hE4, exp_rdy: 4'b1111, exp_ov: 4'b1111};
    tbl[1] = '{v: 4'b1111, dst: 8'hAA, exp_rdy: 4'b0001, exp_ov: 4'b0100};
    tbl[2] = '{v: 4'b1111, dst: 8'h1B, exp_rdy: 4'b1111, exp_ov: 4'b1111};
    tbl[3] = '{v: 4'b0110, dst: 8'h00, exp_rdy: 4'b0010, exp_ov: 4'b0001};
    tbl[4] = '{v: 4'b0000, dst: 8'h00, exp_rdy: 4'b0000, exp_ov: 4'b0000};
    tbl[5] = '{v: 4'b1010, dst: 8'hCC, exp_rdy: 4'b0010, exp_ov: 4'b1000};

    #3;
    chk("reset_ov", 64'(out_valid), 64'h0);
    chk("reset_rdy", 64'(in_ready), 64'h0);
    do_reset();
    cycle_check("idle", r);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      in_valid  = tbl[t].v;
      in_dst    = tbl[t].dst;
      for (int i = 0; i < N; i++) in_data[i] = DW'($urandom);
      out_ready = '1;
      cycle_check("tbl", r);
      chk("tbl_gnt", 64'(r), 64'(tbl[t].exp_rdy));
      chk("tbl_ovq", 64'(out_valid), 64'(tbl[t].exp_ov));
    end

    // Identity
    do_reset();
    in_valid = 4'b1111;
    in_dst   = 8'hE4;
    for (int i = 0; i < N; i++) in_data[i] = DW'(16'h10 + i);
    cycle_check("ident", r);
    chk("ident_ov", 64'(out_valid), 64'hF);
    chk("ident_src", 64'(out_src), 64'hE4);
    chk("ident_data", out_data, 64'h0013_0012_0011_0010);

    // Reversal stream: full bandwidth, no bubbles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = 1'b1;
        in_dst[i]   = W'(3 - i);
        in_data[i]  = DW'(256 * i + k);
      end
      cycle_check("rev", r);
      chk("rev_ovq", 64'(out_valid), 64'hF);
      for (int j = 0; j < N; j++) chk("rev_dataq", 64'(out_data[j]), 64'(256 * (3 - j) + k));
    end
    in_valid = '0;
    cycle_check("rev_end", r);

    // All-to-one on output 2
    do_reset();
    in_valid = 4'b1111;
    in_dst   = 8'hAA;
    for (int i = 0; i < N; i++) in_data[i] = DW'(16'h20 + i);
    for (int k = 0; k < 4; k++) begin
      cycle_check("a2o", r);
      chk("a2o_gnt", 64'(r), 64'(1 << k));
      chk("a2o_src", 64'(out_src[2]), 64'(k));
      chk("a2o_ovq", 64'(out_valid), 64'b0100);
      in_valid[k] = 1'b0;
    end
    in_valid = 4'b1001;
    cycle_check("a2o_wrap", r);
    chk("a2o_wrap_gnt", 64'(r), 64'b0001);
    in_valid = '0;
    cycle_check("a2o_end", r);

    // Backpressure on output 1
    do_reset();
    out_ready  = 4'b1101;
    in_valid   = 4'b1001;
    in_dst     = '0;
    in_dst[0]  = 2'd1;
    in_dst[3]  = 2'd1;
    in_data[0] = 16'hA0;
    in_data[3] = 16'hA3;
    cycle_check("bp", r);
    chk("bp_first", 64'(r), 64'b0001);
    in_data[0] = 16'hA1;
    for (int c = 0; c < 5; c++) begin
      cycle_check("bp_hold", r);
      chk("bp_stall", 64'(r), 64'h0);
      chk("bp_held", 64'(out_data[1]), 64'hA0);
    end
    out_ready = '1;
    cycle_check("bp_rel", r);
    chk("bp_rel_gnt", 64'(r), 64'b1000);
    in_valid[3] = 1'b0;
    cycle_check("bp_rel2", r);
    chk("bp_rel2_gnt", 64'(r), 64'b0001);
    chk("bp_last", 64'(out_data[1]), 64'hA1);
    in_valid = '0;
    cycle_check("bp_end", r);

    // Fairness on output 0
    do_reset();
    in_dst   = '0;
    in_valid = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) in_valid[2] = 1'b1;
      cycle_check("rr", r);
      exp_g = (c < 3 || c % 2 == 0) ? 4'b0001 : 4'b0100;
      chk("rr_gnt", 64'(r), 64'(exp_g));
      for (int i = 0; i < N; i++) if (r[i]) in_data[i] = DW'($urandom);
    end
    in_valid = '0;
    cycle_check("rr_end", r);

    // Asynchronous reset mid-stream
    do_reset();
    out_ready = '0;
    in_valid  = 4'b1011;
    in_dst    = 8'hE4;
    for (int i = 0; i < N; i++) in_data[i] = DW'($urandom);
    cycle_check("ar", r);
    chk("ar_fill", 64'(out_valid), 64'b1011);
    in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ov", 64'(out_valid), 64'h0);
    chk("ar_rdy", 64'(in_ready), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = '1;
    in_dst    = '0;
    cycle_check("ar_after", r);
    chk("ar_first", 64'(r), 64'b0001);
    in_valid = '0;
    cycle_check("ar_end", r);

    // Randomized traffic against the reference
    do_reset();
    for (int c = 0; c < 400; c++) begin
      out_ready = N'($urandom);
      cycle_check("rnd", r);
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || r[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_dst[i]   = W'($urandom);
          in_data[i]  = DW'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
